symbol_packer: RTL and testbench

SYMBOL_PACKER -- requirements
Module: symbol_packer

---
 rtl/symbol_packer_pkg.sv | 16 +
 rtl/sampling_fifo.sv | 62 ++++++
 rtl/symbol_packer.sv | 110 +++++++++++
 tb/tb_symbol_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/symbol_packer_pkg.sv
// Shared sampling constants and the FIFO entry layout used by the symbol
// packer and the upstream coder.
package symbol_packer_pkg;

  localparam int SYMBOL_W = 2;
  localparam int WORD_W   = 32;
  localparam int SYMS     = 16;
  localparam int SYMS_W   = $clog2(SYMS) + 1;   // holds 1..16
  localparam int ENTRY_W  = WORD_W + SYMS_W;    // 37

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [SYMS_W-1:0] syms;
  } word_entry_t;

endpackage

// File: rtl/sampling_fifo.sv
// Show-ahead FIFO for packed sample words.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset (clears pointers)
//   push_i, push_data_i    write request and entry
//   pop_ready_i            consumer ready; pop happens when valid & ready
//   rd_data_o, rd_valid_o  head entry (zero when empty), non-empty flag
//   fill_o                 number of stored entries, 0..DEPTH
//   drop_o                 push refused because full with no pop
module sampling_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_ready_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             full, empty, pop, wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign pop   = !empty && pop_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= push_data_i;
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_q];
  assign fill_o     = cnt_q;

endmodule

// File: rtl/symbol_packer.sv
// Packs 2-bit symbols into 32-bit words (symbol k at bits [2k+1:2k]) and
// queues them in a show-ahead FIFO together with their symbol count.
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   enable, sample_stb        a symbol is accepted when both are high
//   symbol                    2-bit coded sample, stored unaltered
//   flush                     emit the current partial word (ignores enable)
//   word_data/word_syms       FIFO head word and its valid symbol count
//   word_valid/word_ready     head handshake
//   fill_level                words stored
//   overflow/overflow_clr     sticky drop flag and its clear (set wins)
module symbol_packer
  import symbol_packer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SYMS_PARAM = SYMS
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     enable,
  input  logic                     sample_stb,
  input  logic [SYMBOL_W-1:0]      symbol,
  input  logic                     flush,
  output logic [WORD_W-1:0]        word_data,
  output logic [SYMS_W-1:0]        word_syms,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam logic [3:0] LAST_SLOT = 4'(SYMS_PARAM - 1);

  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              ovf_q, ovf_d;

  logic              accept, push, drop;
  logic [WORD_W-1:0] asm_ins;
  logic [SYMS_W-1:0] cnt_ins;
  word_entry_t       push_entry, head_entry;

  assign accept  = sample_stb && enable;
  // Unused slots are always zero, so OR-ing the new symbol in is enough.
  assign asm_ins = asm_q | (WORD_W'(symbol) << {cnt_q, 1'b0});
  assign cnt_ins = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    if (accept) begin
      // The symbol goes in before any flush in the same cycle.
      if (cnt_q == LAST_SLOT || flush) begin
        push       = 1'b1;
        push_entry = '{data: asm_ins, syms: cnt_ins};
        asm_d      = '0;
        cnt_d      = '0;
      end else begin
        asm_d = asm_ins;
        cnt_d = cnt_ins[3:0];
      end
    end else if (flush && cnt_q != '0) begin
      push       = 1'b1;
      push_entry = '{data: asm_q, syms: {1'b0, cnt_q}};
      asm_d      = '0;
      cnt_d      = '0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)              ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      ovf_q <= ovf_d;
    end
  end

  sampling_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_ready_i (word_ready),
    .rd_data_o   (head_entry),
    .rd_valid_o  (word_valid),
    .fill_o      (fill_level),
    .drop_o      (drop)
  );

  assign word_data = head_entry.data;
  assign word_syms = head_entry.syms;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_symbol_packer.sv
module tb_symbol_packer;

  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_stb = 1'b0;
  logic [1:0]  symbol = 2'b00;
  logic        flush = 1'b0;
  logic [31:0] word_data;
  logic [4:0]  word_syms;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [2:0]  fill_level;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  symbol_packer #(.DEPTH(DEPTH)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .sample_stb   (sample_stb),
    .symbol       (symbol),
    .flush        (flush),
    .word_data    (word_data),
    .word_syms    (word_syms),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_seen   = 0;

  // Reference model state
  logic [36:0] exp_q[$];
  logic [31:0] m_asm = '0;
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a word leaves the FIFO at the edge after valid & ready is seen.
  always @(negedge sys_clk) begin
    if (sys_rst_n && word_valid && word_ready) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", {word_data, word_syms}, 37'h0);
      end else begin
        check("word", {word_data, word_syms}, exp_q.pop_front());
      end
    end
  end

  task automatic model_push(input logic [31:0] d, input int s, output logic dropped);
    dropped = 1'b0;
    if (exp_q.size() == DEPTH && !word_ready) dropped = 1'b1;
    else exp_q.push_back({d, 5'(s)});
  endtask

  // One clock of stimulus; the model is updated as the inputs are driven.
  task automatic drive(input logic stb, input logic en, input logic [1:0] sym,
                       input logic fl, input logic clr);
    logic dropped;
    sample_stb = stb; enable = en; symbol = sym; flush = fl; overflow_clr = clr;
    dropped = 1'b0;
    if (stb && en) begin
      m_asm = m_asm | (32'(sym) << (2 * m_cnt));
      m_cnt++;
      if (m_cnt == 16 || fl) begin
        model_push(m_asm, m_cnt, dropped);
        m_asm = '0; m_cnt = 0;
      end
    end else if (fl && m_cnt > 0) begin
      model_push(m_asm, m_cnt, dropped);
      m_asm = '0; m_cnt = 0;
    end
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge sys_clk); #1;
    sample_stb = 1'b0; flush = 1'b0; overflow_clr = 1'b0;
    check("fill_level", 37'(fill_level), 37'(exp_q.size()));
    check("overflow", 37'(overflow), 37'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic full_word(input int base);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 2'((base + i) % 4), 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    int k;
    word_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || word_valid) && k < budget) begin
      idle(1);
      k++;
    end
    check("drain_done", 37'(exp_q.size()), 37'h0);
  endtask

  initial begin
    int seen0;

    // Reset state
    #3;
    check("rst_valid", 37'(word_valid), 37'h0);
    check("rst_fill", 37'(fill_level), 37'h0);
    check("rst_ovf", 37'(overflow), 37'h0);
    check("rst_data", 37'(word_data), 37'h0);
    check("rst_syms", 37'(word_syms), 37'h0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    idle(2);

    // Full word 0,1,0,1,...
    word_ready = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 2'(i % 2), 1'b0, 1'b0);
    check("full_valid_next_cycle", 37'(word_valid), 37'h1);
    check("full_data_val", 37'(word_data), 37'h44444444);
    check("full_syms_val", 37'(word_syms), 37'd16);
    idle(1);
    check("full_valid_one_cycle", 37'(word_valid), 37'h0);

    // Partial flush, then flush with nothing pending
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    check("partial_data", 37'(word_data), 37'h15);
    check("partial_syms", 37'(word_syms), 37'd3);
    idle(2);
    seen0 = n_seen;
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    idle(3);
    check("empty_flush_no_word", 37'(n_seen), 37'(seen0));

    // Enable low holds the partial word; flush works with enable low
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(3);

    // 15 strobes then strobe+flush together: one word of 16
    seen0 = n_seen;
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 2'(i % 4), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    check("simul_syms", 37'(word_syms), 37'd16);
    idle(3);
    check("simul_one_word", 37'(n_seen), 37'(seen0 + 1));
    seen0 = n_seen;
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    idle(3);
    check("simul_counter_zero", 37'(n_seen), 37'(seen0));

    // Overflow with consumer stalled
    word_ready = 1'b0;
    for (int w = 0; w < 5; w++) full_word(w + 1);
    check("ovf_fill", 37'(fill_level), 37'd4);
    check("ovf_set", 37'(overflow), 37'h1);
    check("ovf_head", {word_data, word_syms}, exp_q[0]);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 2'(i % 4), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    check("ovf_set_wins", 37'(overflow), 37'h1);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
    check("ovf_cleared", 37'(overflow), 37'h0);

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 2'(3 - i % 4), 1'b0, 1'b0);
    word_ready = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    word_ready = 1'b0;
    check("pushpop_fill", 37'(fill_level), 37'd4);
    check("pushpop_ovf", 37'(overflow), 37'h0);
    drain(40);

    // Reset mid-word
    word_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst_valid", 37'(word_valid), 37'h0);
    check("midrst_fill", 37'(fill_level), 37'h0);
    check("midrst_ovf", 37'(overflow), 37'h0);
    check("midrst_data", 37'(word_data), 37'h0);
    check("midrst_syms", 37'(word_syms), 37'h0);
    #1 sys_rst_n = 1'b1;
    m_asm = '0; m_cnt = 0; m_ovf = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    check("postrst_data", 37'(word_data), 37'h55555555);
    check("postrst_syms", 37'(word_syms), 37'd16);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
